// File: rtl/range_tracker.sv
`default_nettype none
// ============================================================================
// Module   : range_tracker
// Brief    : Streaming min/max/range/count tracker between go and finish
//            strobes. Optional sum output when RANGE_TRACKER_SUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module range_tracker #(
    parameter int WIDTH = 12,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic             finish,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample_data,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] range_out,
    output logic [CNT_W-1:0] count_out,
`ifdef RANGE_TRACKER_SUM_EN
    output logic [WIDTH+CNT_W-1:0] sum_out,
`endif
    output logic             error
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_run_max, w_run_max;
    logic [WIDTH-1:0]   r_run_min, w_run_min;
    logic [CNT_W-1:0]   r_run_cnt, w_run_cnt;
    logic               w_load;
    logic               w_err;
    logic               w_empty;

    logic               r_busy;
    logic               r_result_valid;
    logic               r_error;
    logic [WIDTH-1:0]   r_max_out;
    logic [WIDTH-1:0]   r_min_out;
    logic [WIDTH-1:0]   r_range_out;
    logic [CNT_W-1:0]   r_count_out;

`ifdef RANGE_TRACKER_SUM_EN
    localparam int c_SUM_W = WIDTH + CNT_W;
    logic [c_SUM_W-1:0] r_run_sum, w_run_sum;
    logic [c_SUM_W-1:0] r_sum_out;
    logic [c_SUM_W:0]   w_sum_ext;

    // One extra bit catches the carry so the accumulator can saturate.
    assign w_sum_ext = {1'b0, r_run_sum} + {{(c_SUM_W+1-WIDTH){1'b0}}, sample_data};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_run_max   = r_run_max;
        w_run_min   = r_run_min;
        w_run_cnt   = r_run_cnt;
`ifdef RANGE_TRACKER_SUM_EN
        w_run_sum   = r_run_sum;
`endif
        w_load      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go && !finish) begin
                    w_state_nxt = S_ACQUIRE;
                    w_run_max   = '0;
                    w_run_min   = '1;
                    w_run_cnt   = '0;
`ifdef RANGE_TRACKER_SUM_EN
                    w_run_sum   = '0;
`endif
                end
                if (finish) w_err = 1'b1;
            end
            S_ACQUIRE: begin
                if (sample_valid) begin
                    if (sample_data > r_run_max) w_run_max = sample_data;
                    if (sample_data < r_run_min) w_run_min = sample_data;
                    if (!(&r_run_cnt))           w_run_cnt = r_run_cnt + 1'b1;
`ifdef RANGE_TRACKER_SUM_EN
                    w_run_sum = w_sum_ext[c_SUM_W] ? '1 : w_sum_ext[c_SUM_W-1:0];
`endif
                end
                // The finish-cycle sample is already folded into w_run_* above.
                if (finish && !go) begin
                    w_state_nxt = S_DONE;
                    w_load      = 1'b1;
                end
                if (finish && go) w_err = 1'b1;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_empty = (w_run_cnt == '0);
        if (w_load && w_empty) w_err = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_run_max      <= '0;
            r_run_min      <= '1;
            r_run_cnt      <= '0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
            r_max_out      <= '0;
            r_min_out      <= '0;
            r_range_out    <= '0;
            r_count_out    <= '0;
`ifdef RANGE_TRACKER_SUM_EN
            r_run_sum      <= '0;
            r_sum_out      <= '0;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_run_max      <= w_run_max;
            r_run_min      <= w_run_min;
            r_run_cnt      <= w_run_cnt;
            r_busy         <= (w_state_nxt == S_ACQUIRE);
            r_result_valid <= (w_state_nxt == S_DONE);
            r_error        <= w_err;
`ifdef RANGE_TRACKER_SUM_EN
            r_run_sum      <= w_run_sum;
`endif
            if (w_load) begin
                if (w_empty) begin
                    r_max_out   <= '0;
                    r_min_out   <= '0;
                    r_range_out <= '0;
                    r_count_out <= '0;
`ifdef RANGE_TRACKER_SUM_EN
                    r_sum_out   <= '0;
`endif
                end else begin
                    r_max_out   <= w_run_max;
                    r_min_out   <= w_run_min;
                    r_range_out <= w_run_max - w_run_min;
                    r_count_out <= w_run_cnt;
`ifdef RANGE_TRACKER_SUM_EN
                    r_sum_out   <= w_run_sum;
`endif
                end
            end
        end
    end

    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign error        = r_error;
    assign max_out      = r_max_out;
    assign min_out      = r_min_out;
    assign range_out    = r_range_out;
    assign count_out    = r_count_out;
`ifdef RANGE_TRACKER_SUM_EN
    assign sum_out      = r_sum_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_range_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_range_tracker
// Brief    : Directed self-checking bench for range_tracker (default and
//            CNT_W=4 instances; sum checks when RANGE_TRACKER_SUM_EN defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_range_tracker;

    logic        clock;
    logic        reset;
    logic        go;
    logic        finish;
    logic        sample_valid;
    logic [11:0] sample_data;

    logic        busy, result_valid, error;
    logic [11:0] max_out, min_out, range_out;
    logic [7:0]  count_out;
    logic        s_busy, s_result_valid, s_error;
    logic [11:0] s_max_out, s_min_out, s_range_out;
    logic [3:0]  s_count_out;
`ifdef RANGE_TRACKER_SUM_EN
    logic [19:0] sum_out;
    logic [15:0] s_sum_out;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    range_tracker #(.WIDTH(12), .CNT_W(8)) u_dut (
        .clock        (clock),
        .reset        (reset),
        .go           (go),
        .finish       (finish),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .busy         (busy),
        .result_valid (result_valid),
        .max_out      (max_out),
        .min_out      (min_out),
        .range_out    (range_out),
        .count_out    (count_out),
`ifdef RANGE_TRACKER_SUM_EN
        .sum_out      (sum_out),
`endif
        .error        (error)
    );

    range_tracker #(.WIDTH(12), .CNT_W(4)) u_sat (
        .clock        (clock),
        .reset        (reset),
        .go           (go),
        .finish       (finish),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .busy         (s_busy),
        .result_valid (s_result_valid),
        .max_out      (s_max_out),
        .min_out      (s_min_out),
        .range_out    (s_range_out),
        .count_out    (s_count_out),
`ifdef RANGE_TRACKER_SUM_EN
        .sum_out      (s_sum_out),
`endif
        .error        (s_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic g, input logic f, input logic v, input logic [11:0] d);
        go = g; finish = f; sample_valid = v; sample_data = d;
        tick();
    endtask

    task automatic check_all(input string tag, input logic rv, input logic er,
                             input logic [11:0] mx, input logic [11:0] mn,
                             input logic [11:0] rg, input logic [7:0] ct);
        check_eq({tag, ".result_valid"}, {31'd0, result_valid}, {31'd0, rv});
        check_eq({tag, ".error"},        {31'd0, error},        {31'd0, er});
        check_eq({tag, ".max"},          {20'd0, max_out},      {20'd0, mx});
        check_eq({tag, ".min"},          {20'd0, min_out},      {20'd0, mn});
        check_eq({tag, ".range"},        {20'd0, range_out},    {20'd0, rg});
        check_eq({tag, ".count"},        {24'd0, count_out},    {24'd0, ct});
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; finish = 1'b0; sample_valid = 1'b0; sample_data = '0;
        tick();
        tick();
        check_all("reset", 1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 8'd0);
        check_eq("reset.busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        // 1. basic capture
        drive(1, 0, 1, 12'd999);   // sample in go cycle is ignored
        check_eq("t1.busy", {31'd0, busy}, 32'd1);
        drive(0, 0, 1, 12'd100);
        drive(0, 0, 0, 12'd0);
        drive(0, 0, 1, 12'd4000);
        drive(0, 0, 1, 12'd7);
        check_eq("t1.no_early_valid", {31'd0, result_valid}, 32'd0);
        drive(0, 1, 0, 12'd0);
        check_all("t1", 1'b1, 1'b0, 12'd4000, 12'd7, 12'd3993, 8'd3);
`ifdef RANGE_TRACKER_SUM_EN
        check_eq("t1.sum", {12'd0, sum_out}, 32'd4107);
`endif
        drive(0, 0, 0, 12'd0);
        check_all("t1.hold", 1'b0, 1'b0, 12'd4000, 12'd7, 12'd3993, 8'd3);
        check_eq("t1.idle_busy", {31'd0, busy}, 32'd0);

        // 2. sample in finish cycle counts
        drive(1, 0, 0, 12'd0);
        drive(0, 0, 1, 12'd50);
        drive(0, 0, 1, 12'd60);
        drive(0, 1, 1, 12'd4095);
        check_all("t2", 1'b1, 1'b0, 12'd4095, 12'd50, 12'd4045, 8'd3);
        drive(0, 0, 0, 12'd0);

        // 3. protocol errors in IDLE
        drive(0, 1, 0, 12'd0);
        check_all("t3.fin_idle", 1'b0, 1'b1, 12'd4095, 12'd50, 12'd4045, 8'd3);
        check_eq("t3.fin_busy", {31'd0, busy}, 32'd0);
        drive(0, 0, 0, 12'd0);
        check_eq("t3.err_pulse", {31'd0, error}, 32'd0);
        drive(1, 1, 0, 12'd0);
        check_eq("t3.gofin_err", {31'd0, error}, 32'd1);
        check_eq("t3.gofin_busy", {31'd0, busy}, 32'd0);
        check_eq("t3.gofin_rv", {31'd0, result_valid}, 32'd0);
        drive(0, 0, 0, 12'd0);
        check_eq("t3.err_clear", {31'd0, error}, 32'd0);

        // go & finish during ACQUIRE: error, capture continues
        drive(1, 0, 0, 12'd0);
        drive(0, 0, 1, 12'd30);
        drive(1, 1, 1, 12'd40);
        check_eq("t3.acq_gofin_err", {31'd0, error}, 32'd1);
        check_eq("t3.acq_gofin_busy", {31'd0, busy}, 32'd1);
        drive(1, 0, 1, 12'd20);    // go alone ignored
        check_eq("t3.acq_go_err", {31'd0, error}, 32'd0);
        drive(0, 1, 0, 12'd0);
        check_all("t3.acq", 1'b1, 1'b0, 12'd40, 12'd20, 12'd20, 8'd3);
        drive(0, 0, 0, 12'd0);

        // 4. empty capture
        drive(1, 0, 0, 12'd0);
        drive(0, 1, 0, 12'd0);
        check_all("t4", 1'b1, 1'b1, 12'd0, 12'd0, 12'd0, 8'd0);
`ifdef RANGE_TRACKER_SUM_EN
        check_eq("t4.sum", {12'd0, sum_out}, 32'd0);
`endif
        drive(0, 0, 0, 12'd0);

        // 5. counter saturation on the CNT_W=4 instance
        drive(1, 0, 0, 12'd0);
        for (int i = 0; i < 20; i++) drive(0, 0, 1, 12'(i));
        drive(0, 1, 0, 12'd0);
        check_eq("t5.sat_rv",    {31'd0, s_result_valid}, 32'd1);
        check_eq("t5.sat_count", {28'd0, s_count_out},    32'd15);
        check_eq("t5.sat_max",   {20'd0, s_max_out},      32'd19);
        check_eq("t5.sat_min",   {20'd0, s_min_out},      32'd0);
        check_eq("t5.sat_range", {20'd0, s_range_out},    32'd19);
        check_eq("t5.wide_count", {24'd0, count_out},     32'd20);
`ifdef RANGE_TRACKER_SUM_EN
        check_eq("t5.sat_sum", {16'd0, s_sum_out}, 32'd190);
`endif
        drive(0, 0, 0, 12'd0);

        // 6. reset mid-capture then fresh capture
        drive(1, 0, 0, 12'd0);
        drive(0, 0, 1, 12'd5);
        reset = 1'b1;
        drive(0, 0, 1, 12'd3000);
        check_all("t6.reset", 1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 8'd0);
        check_eq("t6.reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        drive(1, 0, 0, 12'd0);
        drive(0, 0, 1, 12'd10);
        drive(0, 0, 1, 12'd20);
        drive(0, 1, 0, 12'd0);
        check_all("t6", 1'b1, 1'b0, 12'd20, 12'd10, 12'd10, 8'd2);
`ifdef RANGE_TRACKER_SUM_EN
        check_eq("t6.sum", {12'd0, sum_out}, 32'd30);
`endif
        drive(0, 0, 0, 12'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
